// File: rtl/pattern_gen.sv
// Pattern generator with four selectable sequences (walking-one,
// walking-zero, binary count, Galois LFSR), a programmable advance
// rate and a tri-statable pattern output.
module pattern_gen #(
    parameter int               WIDTH     = 8,
    parameter int               DIV_W     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    input  logic             STEP,
    input  logic [1:0]       MODE,
    input  logic [DIV_W-1:0] DIV,
    input  logic             OE_N,
    output logic [WIDTH-1:0] DOUT,
    output logic             RUNNING,
    output logic             ADV,
    output logic             WRAP
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE_HOT_LSB = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic             adv_q, adv_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] next_pattern;

    // Starting value of each sequence; also the value that flags WRAP.
    function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
        logic [WIDTH-1:0] s;
        case (m)
            2'd0:    s = ONE_HOT_LSB;
            2'd1:    s = ~ONE_HOT_LSB;
            2'd2:    s = '0;
            default: s = ONE_HOT_LSB;
        endcase
        return s;
    endfunction

    // One advance of the sequence selected by m. The LFSR escapes the
    // all-zeros lock-up state by reloading its seed.
    function automatic logic [WIDTH-1:0] advance(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] n;
        case (m)
            2'd0, 2'd1: n = {p[WIDTH-2:0], p[WIDTH-1]};
            2'd2:       n = p + WIDTH'(1);
            default: begin
                if (p == '0) begin
                    n = ONE_HOT_LSB;
                end else begin
                    n = {1'b0, p[WIDTH-1:1]} ^ (p[0] ? LFSR_TAPS : '0);
                end
            end
        endcase
        return n;
    endfunction

    assign next_pattern = advance(mode_q, pattern_q);

    // Next-state and datapath decisions: STOP beats START beats advancing.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        presc_d   = presc_q;
        pattern_d = pattern_q;
        adv_d     = 1'b0;
        wrap_d    = 1'b0;
        if (STOP) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (START) begin
            state_d   = RUN;
            mode_d    = MODE;
            div_d     = DIV;
            presc_d   = '0;
            pattern_d = seed_of(MODE);
        end else begin
            case (state_q)
                RUN: begin
                    if (presc_q == div_q) begin
                        presc_d   = '0;
                        pattern_d = next_pattern;
                        adv_d     = 1'b1;
                        wrap_d    = (next_pattern == seed_of(mode_q));
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
                default: begin
                    if (STEP) begin
                        pattern_d = next_pattern;
                        adv_d     = 1'b1;
                        wrap_d    = (next_pattern == seed_of(mode_q));
                    end
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset to the idle seed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            mode_q    <= 2'd0;
            div_q     <= '0;
            presc_q   <= '0;
            pattern_q <= ONE_HOT_LSB;
            adv_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            presc_q   <= presc_d;
            pattern_q <= pattern_d;
            adv_q     <= adv_d;
            wrap_q    <= wrap_d;
        end
    end

    assign DOUT    = OE_N ? {WIDTH{1'bz}} : pattern_q;
    assign RUNNING = (state_q == RUN);
    assign ADV     = adv_q;
    assign WRAP    = wrap_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: a behavioural model predicts every
// cycle's outputs, a monitor compares them against the DUT.
module tb_pattern_gen;

    logic        clk = 1'b0;
    logic        reset, start, stop, step, oe_n;
    logic [1:0]  mode;
    logic [15:0] div;
    wire  [7:0]  dout;
    logic        running, adv, wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] dout;
        logic       running;
        logic       adv;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit m_run;
    int m_mode, m_div, m_left, m_pat;

    pattern_gen #(.WIDTH(8), .DIV_W(16), .LFSR_TAPS(8'hB8)) dut (
        .CLK(clk), .RESET(reset), .START(start), .STOP(stop), .STEP(step),
        .MODE(mode), .DIV(div), .OE_N(oe_n), .DOUT(dout),
        .RUNNING(running), .ADV(adv), .WRAP(wrap)
    );

    // Weak pull-ups let a released bus read back as all ones.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (dout[g]);
    end

    always #5 clk = ~clk;

    function automatic int seed_of(input int md);
        case (md)
            0:       return 1;
            1:       return 254;
            2:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int next_of(input int md, input int p);
        case (md)
            0, 1:    return ((p * 2) % 256) + (p / 128);
            2:       return (p + 1) % 256;
            default: return (p == 0) ? 1 : ((p / 2) ^ ((p % 2 == 1) ? 'hB8 : 0));
        endcase
    endfunction

    // Drive one cycle of inputs, predict the post-edge outputs, queue them.
    task automatic applyStimulus(input bit r, input bit st, input bit sp,
                                 input bit sk, input int md, input int dv,
                                 input bit oe);
        exp_t e;
        @(negedge clk);
        reset = r; start = st; stop = sp; step = sk;
        mode = 2'(md); div = 16'(dv); oe_n = oe;
        e.adv  = 1'b0;
        e.wrap = 1'b0;
        if (r) begin
            m_run = 0; m_mode = 0; m_div = 0; m_left = 0; m_pat = 1;
        end else if (sp) begin
            m_run = 0;
        end else if (st) begin
            m_run = 1; m_mode = md; m_div = dv; m_left = dv; m_pat = seed_of(md);
        end else if (m_run) begin
            if (m_left == 0) begin
                m_pat  = next_of(m_mode, m_pat);
                e.adv  = 1'b1;
                e.wrap = (m_pat == seed_of(m_mode));
                m_left = m_div;
            end else begin
                m_left--;
            end
        end else if (sk) begin
            m_pat  = next_of(m_mode, m_pat);
            e.adv  = 1'b1;
            e.wrap = (m_pat == seed_of(m_mode));
        end
        e.dout    = oe ? 8'hFF : 8'(m_pat);
        e.running = m_run;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit oe);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, oe);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %02h expected %02h", name, $time, act, req);
        end
    endtask

    // Monitor: after every rising edge, pop one prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("dout",    dout,           e.dout);
                checkOutput("running", {7'd0, running}, {7'd0, e.running});
                checkOutput("adv",     {7'd0, adv},     {7'd0, e.adv});
                checkOutput("wrap",    {7'd0, wrap},    {7'd0, e.wrap});
            end
        end
    end

    initial begin
        int wait_cycles;
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        mode = 2'd0; div = 16'd0; oe_n = 1'b0;

        $display("[TB] reset and walking-one at full rate");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 3, 5, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(10, 0);

        $display("[TB] stop+start together, then three steps");
        applyStimulus(0, 1, 1, 0, 2, 0, 0);
        idle(2, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            idle(2, 0);
        end

        $display("[TB] binary count, divide by four, bus released mid-run");
        applyStimulus(0, 1, 0, 0, 2, 3, 0);
        idle(100, 0);
        idle(21, 1);
        idle(915, 0);

        $display("[TB] LFSR full period");
        applyStimulus(0, 1, 0, 0, 3, 0, 0);
        idle(260, 0);

        $display("[TB] walking-zero then reset mid-run");
        applyStimulus(0, 1, 0, 0, 1, 2, 0);
        idle(7, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(3, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 35,
                          int'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9))
                                                      : int'($urandom_range(0, 3)),
                          $urandom_range(0, 99) < 15);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8, width of the pattern bus; legal range 2..32.
REQ-002 Parameter DIV_W, default 16, width of the rate-divider input.
REQ-003 Parameter LFSR_TAPS, default 8'hB8 zero-extended to WIDTH, Galois feedback mask for LFSR mode.
REQ-004 Port CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 Port RESET  in  1  synchronous, active-high reset.
REQ-006 Port START  in  1  level sampled each cycle: begin or restart the free-running sequence.
REQ-007 Port STOP  in  1  level sampled each cycle: halt the sequence and hold the pattern.
REQ-008 Port STEP  in  1  level sampled each cycle: single advance while idle.
REQ-009 Port MODE  in  2  0 walking-one, 1 walking-zero, 2 binary count, 3 LFSR; latched on START.
REQ-010 Port DIV  in  DIV_W  advance period minus one, in CLK cycles; latched on START.
REQ-011 Port OE_N  in  1  active-low output enable for DOUT; combinational, not registered.
REQ-012 Port DOUT  inout-capable out  WIDTH  pattern when OE_N=0, high-impedance on every bit when OE_N=1.
REQ-013 Port RUNNING  out  1  high while in RUN state.
REQ-014 Port ADV  out  1  one-cycle pulse in the cycle the pattern register holds a newly advanced value.
REQ-015 Port WRAP  out  1  one-cycle pulse, coincident with ADV, when the new value equals the current mode's seed.

Function
REQ-016 State machine SHALL have two states, IDLE and RUN.
REQ-017 Seeds: walking-one {0..0,1}; walking-zero {1..1,0}; count all-zeros; LFSR {0..0,1}.
REQ-018 IDLE + START: latch MODE into mode_q and DIV into div_q, load the seed of the new mode, clear the prescaler, enter RUN next cycle; ADV and WRAP stay low for the load.
REQ-019 RUN + START (STOP low): same reload/relatch as REQ-018, remain in RUN.
REQ-020 STOP asserted in any state: go to/stay in IDLE, pattern held; STOP has priority over START and STEP in the same cycle.
REQ-021 RUN: prescaler counts 0..div_q; in the cycle it equals div_q the pattern advances and the prescaler returns to 0; div_q=0 advances every cycle; div_q=N gives one advance per N+1 cycles.
REQ-022 IDLE + STEP (START and STOP low): advance once using mode_q; STEP held high advances every cycle; STEP ignored in RUN.
REQ-023 Walking-one and walking-zero advance: rotate left by one, bit WIDTH-1 moves to bit 0.
REQ-024 Count advance: add one modulo 2^WIDTH; all-ones wraps to zero.
REQ-025 LFSR advance: shift right by one; if the old bit 0 was 1, XOR result with LFSR_TAPS; if the pattern is ever all-zeros, the advance loads {0..0,1} instead.
REQ-026 ADV and WRAP SHALL be registered and asserted in the same cycle the new pattern value is first visible on DOUT.
REQ-027 DOUT SHALL reflect the pattern register directly, no extra pipeline stage; OE_N affects only drive, never state.

Reset
REQ-028 RESET high at a clock edge: state IDLE, mode_q=0, div_q=0, prescaler=0, pattern={0..0,1}, RUNNING=0, ADV=0, WRAP=0.
REQ-029 RESET has priority over START, STOP and STEP; asserting it mid-sequence discards the prescaler count and pattern.

Verification
REQ-030 Reset, START with MODE=0 DIV=0, WIDTH=8 -> DOUT 01,02,04,...,80,01 on consecutive cycles; WRAP high only on the return to 01.
REQ-031 START with MODE=2 DIV=3 -> ADV every 4th cycle, DOUT 00,01,02...; after 256 advances DOUT=00 with WRAP=1.
REQ-032 START with MODE=3 DIV=0, taps B8 -> 255 distinct nonzero values before WRAP, DOUT=01 at WRAP; forced-zero state recovers to 01.
REQ-033 RUN then STOP and START same cycle -> IDLE, pattern frozen; three STEP pulses -> exactly three advances and three ADV pulses.
REQ-034 OE_N=1 during RUN -> DOUT all Z while ADV keeps pulsing; OE_N=0 -> DOUT shows correct current value with no phase slip.
REQ-035 RESET asserted mid-RUN at arbitrary prescaler count -> next cycle IDLE, DOUT=01, RUNNING=0, no ADV.
